// File: rtl/disparity_writer.sv
`default_nettype none
// ============================================================================
//  Module      : disparity_writer
//  Description : Converts a 6-bit disparity stream to 8-bit grayscale, tracks
//                the raster position, packs four pixels per 32-bit word,
//                queues the words in a FIFO and writes them to the frame
//                buffer over an Avalon-MM write master.
//  Revision    : 1.0  initial release
// ============================================================================
module disparity_writer #(
  parameter int          DISP_BITS  = 6,
  parameter int          IMG_W      = 640,
  parameter int          IMG_H      = 480,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_start,
  input  logic                          disparity_val,
  input  logic [DISP_BITS-1:0]          disparity,
  output logic [31:0]                   avm_address,
  output logic [31:0]                   avm_writedata,
  output logic [3:0]                    avm_byteenable,
  output logic                          avm_write,
  input  logic                          avm_waitrequest,
  output logic [9:0]                    pixel_x,
  output logic [9:0]                    pixel_y,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          frame_done
);

  localparam int         c_ptr_w   = $clog2(FIFO_DEPTH);
  localparam int         c_lvl_w   = c_ptr_w + 1;
  localparam int         c_entry_w = 1 + 32 + 32;
  localparam logic [9:0] c_x_last  = 10'(IMG_W - 1);
  localparam logic [9:0] c_y_last  = 10'(IMG_H - 1);
  localparam logic [c_lvl_w-1:0] c_lvl_full = c_lvl_w'(FIFO_DEPTH);

  // Expand a disparity to 8 bits by repeating its MSBs into the low bits,
  // so zero maps to 0x00 and full scale maps to 0xFF.
  function automatic logic [7:0] f_gray(input logic [DISP_BITS-1:0] d);
    logic [7:0] g;
    g = '0;
    for (int i = 0; i < 8; i++) begin
      g[7-i] = d[DISP_BITS-1-(i % DISP_BITS)];
    end
    return g;
  endfunction

  // Registered state
  logic [9:0]           r_pixel_x;
  logic [9:0]           r_pixel_y;
  logic [23:0]          r_pack;      // byte lanes 0..2 of the word being built
  logic [31:0]          r_addr;
  logic [c_entry_w-1:0] r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_lvl_w-1:0]   r_level;
  logic                 r_overflow;
  logic                 r_frame_done;

  // Combinational
  logic [9:0]           w_cur_x;
  logic [9:0]           w_cur_y;
  logic [23:0]          w_cur_pack;
  logic [31:0]          w_cur_addr;
  logic [1:0]           w_lane;
  logic [7:0]           w_gray;
  logic                 w_push;
  logic                 w_last;
  logic [c_entry_w-1:0] w_push_entry;
  logic [c_entry_w-1:0] w_head;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_push_ok;
  logic                 w_drop;

  // A frame_start in the same cycle as a pixel makes that pixel (0,0),
  // so the effective position/pack/address are the cleared values.
  always_comb begin
    w_cur_x    = frame_start ? 10'd0 : r_pixel_x;
    w_cur_y    = frame_start ? 10'd0 : r_pixel_y;
    w_cur_pack = frame_start ? 24'd0 : r_pack;
    w_cur_addr = frame_start ? BASE_ADDR : r_addr;
    w_lane     = w_cur_x[1:0];
    w_gray     = f_gray(disparity);
    w_push     = disparity_val && (w_lane == 2'd3);
    w_last     = (w_cur_x == c_x_last) && (w_cur_y == c_y_last);
    w_push_entry = {w_last, w_cur_addr, w_gray, w_cur_pack};
  end

  // FIFO status and handshake; a full FIFO still accepts a push when the
  // head is leaving in the same cycle.
  always_comb begin
    w_head    = r_mem[r_rd_ptr];
    w_empty   = (r_level == '0);
    w_full    = (r_level == c_lvl_full);
    w_pop     = !w_empty && !avm_waitrequest;
    w_push_ok = w_push && (!w_full || w_pop);
    w_drop    = w_push && w_full && !w_pop;
  end

  // Raster position of the next expected pixel
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pixel_x <= 10'd0;
      r_pixel_y <= 10'd0;
    end else if (disparity_val) begin
      if (w_cur_x == c_x_last) begin
        r_pixel_x <= 10'd0;
        r_pixel_y <= (w_cur_y == c_y_last) ? 10'd0 : w_cur_y + 10'd1;
      end else begin
        r_pixel_x <= w_cur_x + 10'd1;
        r_pixel_y <= w_cur_y;
      end
    end else if (frame_start) begin
      r_pixel_x <= 10'd0;
      r_pixel_y <= 10'd0;
    end
  end

  // Collect the first three grayscale bytes of each word (little-endian)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pack <= 24'd0;
    end else if (disparity_val) begin
      r_pack <= w_cur_pack;
      case (w_lane)
        2'd0:    r_pack[7:0]   <= w_gray;
        2'd1:    r_pack[15:8]  <= w_gray;
        2'd2:    r_pack[23:16] <= w_gray;
        default: ;
      endcase
    end else if (frame_start) begin
      r_pack <= 24'd0;
    end
  end

  // Word address: advances per completed word, wraps after the frame's last
  // word; it advances even when the word is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr <= BASE_ADDR;
    end else if (w_push) begin
      r_addr <= w_last ? BASE_ADDR : w_cur_addr + 32'd4;
    end else if (frame_start) begin
      r_addr <= BASE_ADDR;
    end
  end

  // FIFO storage; contents are don't-care outside the occupied range
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= w_push_entry;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= r_level + c_lvl_w'(w_push_ok) - c_lvl_w'(w_pop);
    end
  end

  // Sticky overflow and end-of-frame pulse on acceptance of the last word
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_drop) r_overflow <= 1'b1;
      r_frame_done <= w_pop && w_head[c_entry_w-1];
    end
  end

  assign avm_write      = !w_empty;
  assign avm_address    = w_head[63:32];
  assign avm_writedata  = w_head[31:0];
  assign avm_byteenable = 4'hF;
  assign pixel_x        = r_pixel_x;
  assign pixel_y        = r_pixel_y;
  assign fifo_level     = r_level;
  assign overflow       = r_overflow;
  assign frame_done     = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_disparity_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_disparity_writer
//  Description : Directed and random stimulus for disparity_writer, checked
//                every cycle against a pixel-index reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_disparity_writer;

  localparam int          c_w     = 8;
  localparam int          c_h     = 2;
  localparam logic [31:0] c_base  = 32'h0000_0000;
  localparam int          c_depth = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic        disparity_val = 1'b0;
  logic [5:0]  disparity = 6'd0;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_address;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_write;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic        frame_done;

  disparity_writer #(
    .DISP_BITS (6),
    .IMG_W     (c_w),
    .IMG_H     (c_h),
    .BASE_ADDR (c_base),
    .FIFO_DEPTH(c_depth)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .frame_start    (frame_start),
    .disparity_val  (disparity_val),
    .disparity      (disparity),
    .avm_address    (avm_address),
    .avm_writedata  (avm_writedata),
    .avm_byteenable (avm_byteenable),
    .avm_write      (avm_write),
    .avm_waitrequest(avm_waitrequest),
    .pixel_x        (pixel_x),
    .pixel_y        (pixel_y),
    .fifo_level     (fifo_level),
    .overflow       (overflow),
    .frame_done     (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        last;
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

  // Reference model state: linear pixel index within the frame, the bytes
  // of the word in progress, and the queue of words awaiting the bus.
  entry_t     m_q[$];
  int         m_p = 0;
  logic [7:0] m_bytes [4];
  logic       m_ovf = 1'b0;
  logic       m_fd = 1'b0;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic model_edge(input logic r, input logic fs, input logic v,
                            input logic [5:0] d, input logic wr);
    logic   pop;
    logic   popped_last;
    entry_t e;
    int     lane;
    if (r) begin
      m_q.delete();
      m_p = 0;
      for (int i = 0; i < 4; i++) m_bytes[i] = 8'd0;
      m_ovf = 1'b0;
      m_fd = 1'b0;
      return;
    end
    pop = (m_q.size() != 0) && !wr;
    popped_last = pop && m_q[0].last;
    if (pop) void'(m_q.pop_front());
    if (fs) begin
      m_p = 0;
      for (int i = 0; i < 4; i++) m_bytes[i] = 8'd0;
    end
    if (v) begin
      lane = m_p % 4;
      m_bytes[lane] = 8'((int'(d) * 4) + (int'(d) / 16));
      if (lane == 3) begin
        e.last = (m_p == c_w * c_h - 1);
        e.addr = c_base + 32'((m_p / 4) * 4);
        e.data = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
        if (m_q.size() < c_depth) m_q.push_back(e);
        else m_ovf = 1'b1;
      end
      m_p = (m_p + 1) % (c_w * c_h);
    end
    m_fd = popped_last;
  endtask

  task automatic check_all();
    chk("avm_write", {31'd0, avm_write}, {31'd0, m_q.size() != 0});
    if (m_q.size() != 0) begin
      chk("avm_address", avm_address, m_q[0].addr);
      chk("avm_writedata", avm_writedata, m_q[0].data);
    end
    chk("byteenable", {28'd0, avm_byteenable}, 32'hF);
    chk("fifo_level", {29'd0, fifo_level}, 32'(m_q.size()));
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    chk("frame_done", {31'd0, frame_done}, {31'd0, m_fd});
    chk("pixel_x", {22'd0, pixel_x}, 32'(m_p % c_w));
    chk("pixel_y", {22'd0, pixel_y}, 32'(m_p / c_w));
  endtask

  // Apply inputs for one cycle, clock it, update the model, then check
  task automatic cyc(input logic r, input logic fs, input logic v,
                     input logic [5:0] d, input logic wr);
    reset = r;
    frame_start = fs;
    disparity_val = v;
    disparity = d;
    avm_waitrequest = wr;
    @(posedge clk);
    model_edge(r, fs, v, d, wr);
    #1;
    check_all();
  endtask

  initial begin
    logic [5:0] seq [4];

    // Reset state
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("rst_write", {31'd0, avm_write}, 32'd0);
    chk("rst_level", {29'd0, fifo_level}, 32'd0);

    // One word, no stall: written the cycle after the 4th pixel, one cycle
    seq[0] = 6'd0; seq[1] = 6'd21; seq[2] = 6'd42; seq[3] = 6'd63;
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, seq[i], 0);
    chk("t1_write", {31'd0, avm_write}, 32'd1);
    chk("t1_addr", avm_address, c_base);
    chk("t1_data", avm_writedata, 32'hFFAA_5500);
    cyc(0, 0, 0, 0, 0);
    chk("t1_write_done", {31'd0, avm_write}, 32'd0);

    // Same word under a 5-cycle stall
    cyc(0, 1, 1, seq[0], 1);
    for (int i = 1; i < 4; i++) cyc(0, 0, 1, seq[i], 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1);
    chk("t2_held_data", avm_writedata, 32'hFFAA_5500);
    cyc(0, 0, 0, 0, 0);
    chk("t2_level", {29'd0, fifo_level}, 32'd0);

    // Partial word abandoned by frame_start
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 6'd9, 0);
    cyc(0, 0, 1, 6'd33, 0);
    cyc(0, 1, 1, 6'd1, 0);
    cyc(0, 0, 1, 6'd2, 0);
    cyc(0, 0, 1, 6'd3, 0);
    cyc(0, 0, 1, 6'd4, 0);
    chk("t5_addr", avm_address, c_base);
    chk("t5_data", avm_writedata, 32'h100C_0804);
    cyc(0, 0, 0, 0, 0);

    // Full frame with gapped valids: four words and one frame_done
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < c_w * c_h; i++) begin
      cyc(0, 0, 1, 6'($urandom_range(0, 63)), 0);
      if (i % 3 == 0) cyc(0, 0, 0, 0, 0);
    end
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("t3_px", {22'd0, pixel_x}, 32'd0);
    chk("t3_py", {22'd0, pixel_y}, 32'd0);

    // Overflow: 5 words into a 4-deep FIFO under stall
    cyc(0, 1, 0, 0, 1);
    for (int i = 0; i < 20; i++) cyc(0, 0, 1, 6'($urandom_range(0, 63)), 1);
    chk("t4_ovf", {31'd0, overflow}, 32'd1);
    chk("t4_level", {29'd0, fifo_level}, 32'd4);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0);
    chk("t4_ovf_sticky", {31'd0, overflow}, 32'd1);

    // Reset with three words queued under stall
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) cyc(0, 0, 1, 6'($urandom_range(0, 63)), 1);
    chk("t6_level_pre", {29'd0, fifo_level}, 32'd3);
    cyc(1, 0, 0, 0, 1);
    chk("t6_write", {31'd0, avm_write}, 32'd0);
    chk("t6_level", {29'd0, fifo_level}, 32'd0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 199) == 0),
          ($urandom_range(0, 49) == 0),
          ($urandom_range(0, 9) < 7),
          6'($urandom_range(0, 63)),
          ($urandom_range(0, 9) < 4));
    end
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
